// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared types and constants for the MIPS32 memory responder
package mips32_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 10;
    localparam int WAIT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic OP_LW = 1'b0;
    localparam logic OP_SW = 1'b1;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/mips32_mem_responder_if.sv
// rtl/mips32_mem_responder_if.sv - request/response handshake bundle between pipeline and memory
interface mips32_mem_responder_if #(
    parameter int DATA_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mips32_mem_array.sv
// rtl/mips32_mem_array.sv - single-port synchronous word RAM with registered read data, no reset
module mips32_mem_array
    import mips32_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read data only moves on a load, so it stays put for the whole response.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mips32_mem_responder.sv
// rtl/mips32_mem_responder.sv - wait-state data memory responder; MEM_BOUNDS_ERR_EN flags out-of-range addresses
module mips32_mem_responder
    import mips32_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_STATES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mips32_mem_responder_if.slave    bus
);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

    state_e              state_q;
    logic [WAIT_W-1:0]   cnt_q;
    logic                we_q;
    logic                err_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                req_oob;
    logic                commit;
    logic [DATA_W-1:0]   ram_rdata;

`ifdef MEM_BOUNDS_ERR_EN
    assign req_oob = |bus.req_addr[31:ADDR_W];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];
    assign req_oob        = 1'b0;
`endif

    // The access is committed on the edge that moves WAIT into RESP, so the
    // counter reaching zero is the one cycle the RAM is enabled.
    assign commit = (state_q == ST_WAIT) && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= OP_LW;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        addr_q  <= bus.req_addr[ADDR_W-1:0];
                        wdata_q <= bus.req_wdata;
                        err_q   <= req_oob;
                        cnt_q   <= WAIT_INIT;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    mips32_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk_i   (clk),
        .en_i    (commit),
        .we_i    (we_q && !err_q),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    // Stores and rejected accesses report zero data.
    assign bus.rsp_rdata = (bus.rsp_valid && (we_q == OP_LW) && !err_q) ? ram_rdata : '0;
    assign bus.rsp_err   = bus.rsp_valid && err_q;

endmodule

// File: tb/tb_mips32_mem_responder.sv
// tb/tb_mips32_mem_responder.sv - directed bench for mips32_mem_responder; honours MEM_BOUNDS_ERR_EN
module tb_mips32_mem_responder;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

`ifdef MEM_BOUNDS_ERR_EN
    localparam bit BND = 1'b1;
`else
    localparam bit BND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    mips32_mem_responder_if #(.DATA_W(32)) if_a ();
    mips32_mem_responder_if #(.DATA_W(32)) if_b ();

    mips32_mem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_STATES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a));
    mips32_mem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_STATES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b));

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic logic g_req_ready(input bit sel);
        return sel ? if_b.req_ready : if_a.req_ready;
    endfunction
    function automatic logic g_rsp_valid(input bit sel);
        return sel ? if_b.rsp_valid : if_a.rsp_valid;
    endfunction
    function automatic logic [31:0] g_rdata(input bit sel);
        return sel ? if_b.rsp_rdata : if_a.rsp_rdata;
    endfunction
    function automatic logic g_err(input bit sel);
        return sel ? if_b.rsp_err : if_a.rsp_err;
    endfunction

    task automatic set_req(input bit sel, input bit v, input bit we, input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            if_b.req_valid = v; if_b.req_we = we; if_b.req_addr = a; if_b.req_wdata = d;
        end else begin
            if_a.req_valid = v; if_a.req_we = we; if_a.req_addr = a; if_a.req_wdata = d;
        end
    endtask

    task automatic set_rdy(input bit sel, input bit r);
        if (sel) if_b.rsp_ready = r;
        else     if_a.rsp_ready = r;
    endtask

    task automatic wait_ready(input bit sel);
        int w = 0;
        while (!g_req_ready(sel) && w < 20) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic txn(input bit sel, input vec_t v, input int exp_lat, input string tag);
        int lat;
        @(negedge clk);
        set_req(sel, 1'b1, v.we, v.addr, v.wdata);
        set_rdy(sel, 1'b1);
        wait_ready(sel);
        @(posedge clk); #1;
        set_req(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); lat++; #1;
            if (g_rsp_valid(sel)) break;
        end
        chk({tag, "_lat"},   32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, g_rdata(sel), v.exp_rdata);
        chk({tag, "_err"},   32'(g_err(sel)), 32'(v.exp_err));
        @(posedge clk); #1;
        chk({tag, "_idle"},  {30'd0, g_rsp_valid(sel), g_req_ready(sel)}, 32'd1);
    endtask

    vec_t        vecs [10];
    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_exp  [4];

    initial begin
        vec_t v;
        int   acc_cyc [4];
        logic [31:0] rsp_q [$];
        int   n_acc;

        vecs[0] = '{1'b1, 32'd5,    32'h0000_1111, 32'h0, 1'b0};
        vecs[1] = '{1'b1, 32'd7,    32'h0000_001E, 32'h0, 1'b0};
        vecs[2] = '{1'b0, 32'd7,    32'h0,         32'h0000_001E, 1'b0};
        vecs[3] = '{1'b1, 32'd3,    32'h0000_0055, 32'h0, 1'b0};
        vecs[4] = '{1'b0, 32'd3,    32'h0,         32'h0000_0055, 1'b0};
        vecs[5] = '{1'b1, 32'd1027, 32'h0000_0099, 32'h0, BND};
        vecs[6] = '{1'b0, 32'd3,    32'h0,         BND ? 32'h55 : 32'h99, 1'b0};
        vecs[7] = '{1'b0, 32'd1027, 32'h0,         BND ? 32'h0 : 32'h99, BND};
        vecs[8] = '{1'b1, 32'd1023, 32'h0000_ABCD, 32'h0, 1'b0};
        vecs[9] = '{1'b0, 32'd1023, 32'h0,         32'h0000_ABCD, 1'b0};
        b2b_addr = '{32'd7, 32'd5, 32'd1023, 32'd7};
        b2b_exp  = '{32'h1E, 32'h1111, 32'hABCD, 32'h1E};

        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); set_rdy(1'b0, 1'b0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0); set_rdy(1'b1, 1'b0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(if_a.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(if_a.rsp_valid), 32'd0);
        chk("rst_rdata",     if_a.rsp_rdata, 32'h0);
        chk("rst_b_ready",   32'(if_b.req_ready), 32'd1);
        rst_n = 1'b1;

        // Table of single transactions, two wait states
        for (int i = 0; i < 10; i++) txn(1'b0, vecs[i], 3, $sformatf("vec%0d", i));

        // Reset in the middle of WAIT discards an uncommitted store
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b1, 32'd5, 32'h0000_DEAD);
        wait_ready(1'b0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1 chk("midrst_ready_async", 32'(if_a.req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 32'(if_a.req_ready), 32'd1);
        chk("midrst_valid", 32'(if_a.rsp_valid), 32'd0);
        chk("midrst_rdata", if_a.rsp_rdata, 32'h0);
        v = '{1'b0, 32'd5, 32'h0, 32'h0000_1111, 1'b0};
        txn(1'b0, v, 3, "midrst_load5");

        // Backpressure: response held, new request ignored
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 32'd7, 32'h0);
        set_rdy(1'b0, 1'b0);
        wait_ready(1'b0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b1, 32'd7, 32'h0000_0BAD);
        for (int w = 0; w < 20 && !if_a.rsp_valid; w++) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp_valid%0d", c), 32'(if_a.rsp_valid), 32'd1);
            chk($sformatf("bp_rdata%0d", c), if_a.rsp_rdata, 32'h1E);
            chk($sformatf("bp_ready%0d", c), 32'(if_a.req_ready), 32'd0);
        end
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_rdy(1'b0, 1'b1);
        @(posedge clk); #1;
        chk("bp_release", {30'd0, if_a.rsp_valid, if_a.req_ready}, 32'd1);
        v = '{1'b0, 32'd7, 32'h0, 32'h0000_001E, 1'b0};
        txn(1'b0, v, 3, "bp_reload7");

        // Zero wait states
        v = '{1'b1, 32'd0, 32'h0000_0077, 32'h0, 1'b0};
        txn(1'b1, v, 1, "ws0_store0");
        v = '{1'b0, 32'd0, 32'h0, 32'h0000_0077, 1'b0};
        txn(1'b1, v, 1, "ws0_load0");

        // Back-to-back loads with both sides always ready
        n_acc = 0;
        @(negedge clk);
        set_rdy(1'b0, 1'b1);
        set_req(1'b0, 1'b1, 1'b0, b2b_addr[0], 32'h0);
        for (int cyc = 0; cyc < 100 && rsp_q.size() < 4; cyc++) begin
            if (n_acc >= 4) if_a.req_valid = 1'b0;
            else            if_a.req_addr  = b2b_addr[n_acc];
            if (if_a.rsp_valid) rsp_q.push_back(if_a.rsp_rdata);
            if (if_a.req_ready && if_a.req_valid) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            @(negedge clk);
        end
        if_a.req_valid = 1'b0;
        chk("b2b_accepts", 32'(n_acc), 32'd4);
        chk("b2b_responses", 32'(rsp_q.size()), 32'd4);
        for (int i = 1; i < 4 && i < n_acc; i++)
            chk($sformatf("b2b_spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd5);
        for (int i = 0; i < rsp_q.size(); i++)
            chk($sformatf("b2b_rdata%0d", i), rsp_q[i], b2b_exp[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
